// File: rtl/prom_seq_pkg.sv
// Shared constants, encodings and helpers for the PROM sequencer.
package prom_seq_pkg;

    // SPI flash opcodes
    localparam logic [7:0] OPC_WREN = 8'h06;
    localparam logic [7:0] OPC_RDSR = 8'h05;
    localparam logic [7:0] OPC_SE   = 8'hD8;
    localparam logic [7:0] OPC_BE   = 8'hC7;
    localparam logic [7:0] OPC_WRSR = 8'h01;

    localparam logic [31:0] CMD_WREN = {OPC_WREN, 24'h000000};
    localparam logic [31:0] CMD_RDSR = {OPC_RDSR, 24'h000000};

    // seq_op encodings
    localparam logic [1:0] OP_SECTOR_ERASE = 2'd0;
    localparam logic [1:0] OP_BULK_ERASE   = 2'd1;
    localparam logic [1:0] OP_WRITE_SR     = 2'd2;
    localparam logic [1:0] OP_POLL_ONLY    = 2'd3;

    // Sequence error codes
    localparam logic [3:0] ERR_OK      = 4'd0;
    localparam logic [3:0] ERR_WEL     = 4'd1;
    localparam logic [3:0] ERR_TIMEOUT = 4'd2;
    localparam logic [3:0] ERR_HANG    = 4'd3;
    localparam logic [3:0] ERR_REJECT  = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WREN    = 3'd1,
        ST_WEL_CHK = 3'd2,
        ST_OPCMD   = 3'd3,
        ST_GAP     = 3'd4,
        ST_POLL    = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    typedef enum logic [2:0] {
        IS_IDLE      = 3'd0,
        IS_WAIT_IDLE = 3'd1,
        IS_ISSUE     = 3'd2,
        IS_WAIT_BUSY = 3'd3,
        IS_WAIT_DONE = 3'd4
    } iss_state_t;

    // Command word for the operation-specific step of a sequence.
    function automatic logic [31:0] op_cmd_word(input logic [1:0] op,
                                                input logic [23:0] addr,
                                                input logic [7:0] sr);
        logic [31:0] w;
        case (op)
            OP_SECTOR_ERASE: w = {OPC_SE, addr};
            OP_BULK_ERASE:   w = {OPC_BE, 24'h000000};
            OP_WRITE_SR:     w = {OPC_WRSR, sr, 16'h0000};
            default:         w = CMD_RDSR;
        endcase
        return w;
    endfunction

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/prom_seq_ctrl_issuer.sv
// Single-command handshake with the SPI engine; also owns the engine command
// port so host pass-through and sequencer commands share one register.
module prom_cmd_issuer
    import prom_seq_pkg::*;
#(
    parameter int ENG_LAUNCH_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [31:0] cmd,
    input  logic        fwd,
    input  logic [31:0] fwd_cmd,
    input  logic [2:0]  eng_state,
    input  logic [7:0]  eng_sr,
    output logic [31:0] eng_cmd,
    output logic        eng_cmd_wen,
    output logic        done,
    output logic        hang,
    output logic [7:0]  result
);

    localparam logic [15:0] LAUNCH_LAST = 16'(ENG_LAUNCH_MAX - 1);

    iss_state_t  state_r, state_next_s;
    logic [15:0] launch_cnt_r;
    logic [31:0] eng_cmd_r;
    logic        eng_cmd_wen_r;
    logic        done_r;
    logic        hang_r;
    logic [7:0]  result_r;

    // Next-state logic of the command handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IS_IDLE: begin
                if (go) state_next_s = IS_WAIT_IDLE;
                else    state_next_s = IS_IDLE;
            end
            IS_WAIT_IDLE: begin
                if (eng_state == 3'd0) state_next_s = IS_ISSUE;
                else                   state_next_s = IS_WAIT_IDLE;
            end
            IS_ISSUE: state_next_s = IS_WAIT_BUSY;
            IS_WAIT_BUSY: begin
                if (eng_state != 3'd0)              state_next_s = IS_WAIT_DONE;
                else if (launch_cnt_r == LAUNCH_LAST) state_next_s = IS_IDLE;
                else                                state_next_s = IS_WAIT_BUSY;
            end
            IS_WAIT_DONE: begin
                if (eng_state == 3'd0) state_next_s = IS_IDLE;
                else                   state_next_s = IS_WAIT_DONE;
            end
            default: state_next_s = IS_IDLE;
        endcase
    end

    // State, strobe, launch watchdog and result capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IS_IDLE;
            launch_cnt_r  <= 16'd0;
            eng_cmd_r     <= 32'd0;
            eng_cmd_wen_r <= 1'b0;
            done_r        <= 1'b0;
            hang_r        <= 1'b0;
            result_r      <= 8'd0;
        end else begin
            state_r       <= state_next_s;
            eng_cmd_wen_r <= 1'b0;
            done_r        <= 1'b0;
            hang_r        <= 1'b0;
            // The strobe is registered on entry to ISSUE, so it is high in ISSUE.
            if (state_r == IS_WAIT_IDLE && state_next_s == IS_ISSUE) begin
                eng_cmd_r     <= cmd;
                eng_cmd_wen_r <= 1'b1;
            end else if (fwd) begin
                eng_cmd_r     <= fwd_cmd;
                eng_cmd_wen_r <= 1'b1;
            end
            if (state_r == IS_WAIT_BUSY) launch_cnt_r <= launch_cnt_r + 16'd1;
            else                         launch_cnt_r <= 16'd0;
            if (state_r == IS_WAIT_BUSY && state_next_s == IS_IDLE) hang_r <= 1'b1;
            if (state_r == IS_WAIT_DONE && state_next_s == IS_IDLE) begin
                done_r   <= 1'b1;
                result_r <= eng_sr;
            end
        end
    end

    assign eng_cmd     = eng_cmd_r;
    assign eng_cmd_wen = eng_cmd_wen_r;
    assign done        = done_r;
    assign hang        = hang_r;
    assign result      = result_r;

endmodule

// File: rtl/prom_seq_ctrl.sv
// PROM operation sequencer: WREN / WEL check / op command / WIP polling,
// arbitrating the engine command port against direct host quadlets.
module prom_seq_ctrl
    import prom_seq_pkg::*;
#(
    parameter int POLL_GAP       = 1000,
    parameter int POLL_MAX       = 16'hFFFF,
    parameter int ENG_LAUNCH_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] host_cmd,
    input  logic        host_cmd_wen,
    output logic        host_reject,
    input  logic        seq_start,
    input  logic [1:0]  seq_op,
    input  logic [23:0] seq_addr,
    input  logic [7:0]  seq_sr,
    output logic        seq_busy,
    output logic        seq_done,
    output logic [31:0] seq_status,
    output logic [31:0] eng_cmd,
    output logic        eng_cmd_wen,
    input  logic [2:0]  eng_state,
    input  logic [31:0] eng_result
);

    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);
    localparam logic [31:0] GAP_LEN    = 32'(POLL_GAP);

    seq_state_t  state_r, state_next_s;
    logic [15:0] poll_cnt_r;
    logic [7:0]  last_sr_r;
    logic [3:0]  err_r;
    logic        busy_r, done_r, reject_r;
    logic [31:0] gap_cnt_r;
    logic [1:0]  op_r;
    logic [23:0] addr_r;
    logic [7:0]  sr_r;

    logic        iss_go_s, iss_done_s, iss_hang_s;
    logic [31:0] iss_cmd_s;
    logic [7:0]  iss_result_s;
    logic        fin_s, poll_upd_s;
    logic [3:0]  fin_err_s;
    logic [15:0] new_cnt_s;
    logic        unused_result_s;

    // Only the status byte of the engine result matters here.
    assign unused_result_s = ^eng_result[31:8];

    prom_cmd_issuer #(.ENG_LAUNCH_MAX(ENG_LAUNCH_MAX)) u_issuer (
        .clk         (clk),
        .reset       (reset),
        .go          (iss_go_s),
        .cmd         (iss_cmd_s),
        .fwd         (host_cmd_wen && !busy_r),
        .fwd_cmd     (host_cmd),
        .eng_state   (eng_state),
        .eng_sr      (eng_result[7:0]),
        .eng_cmd     (eng_cmd),
        .eng_cmd_wen (eng_cmd_wen),
        .done        (iss_done_s),
        .hang        (iss_hang_s),
        .result      (iss_result_s)
    );

    // Sequencer next state, issuer request and end-of-sequence decision
    always_comb begin
        state_next_s = state_r;
        iss_go_s     = 1'b0;
        iss_cmd_s    = CMD_RDSR;
        fin_s        = 1'b0;
        fin_err_s    = ERR_OK;
        poll_upd_s   = 1'b0;
        new_cnt_s    = sat_inc16(poll_cnt_r);
        case (state_r)
            ST_IDLE: begin
                if (seq_start && !host_cmd_wen)
                    state_next_s = (seq_op == OP_POLL_ONLY) ? ST_GAP : ST_WREN;
                else
                    state_next_s = ST_IDLE;
            end
            ST_WREN, ST_WEL_CHK, ST_OPCMD, ST_POLL: begin
                // Hold the request until the issuer reports; suppress re-trigger on its report cycle.
                iss_go_s = !iss_done_s && !iss_hang_s;
                if (state_r == ST_WREN)       iss_cmd_s = CMD_WREN;
                else if (state_r == ST_OPCMD) iss_cmd_s = op_cmd_word(op_r, addr_r, sr_r);
                else                          iss_cmd_s = CMD_RDSR;
                if (iss_hang_s) begin
                    fin_s        = 1'b1;
                    fin_err_s    = ERR_HANG;
                    state_next_s = ST_DONE;
                end else if (iss_done_s) begin
                    if (state_r == ST_WREN) begin
                        state_next_s = ST_WEL_CHK;
                    end else if (state_r == ST_WEL_CHK) begin
                        if (iss_result_s[1] == 1'b0) begin
                            fin_s        = 1'b1;
                            fin_err_s    = ERR_WEL;
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_OPCMD;
                        end
                    end else if (state_r == ST_OPCMD) begin
                        state_next_s = ST_GAP;
                    end else begin
                        poll_upd_s = 1'b1;
                        if (iss_result_s[0] == 1'b0) begin
                            fin_s        = 1'b1;
                            fin_err_s    = ERR_OK;
                            state_next_s = ST_DONE;
                        end else if (new_cnt_s >= POLL_LIMIT) begin
                            fin_s        = 1'b1;
                            fin_err_s    = ERR_TIMEOUT;
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_GAP;
                        end
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r + 32'd1 >= GAP_LEN) state_next_s = ST_POLL;
                else                              state_next_s = ST_GAP;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sequencer state, status fields and one-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            poll_cnt_r <= 16'd0;
            last_sr_r  <= 8'd0;
            err_r      <= ERR_OK;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            reject_r   <= 1'b0;
            gap_cnt_r  <= 32'd0;
            op_r       <= 2'd0;
            addr_r     <= 24'd0;
            sr_r       <= 8'd0;
        end else begin
            state_r  <= state_next_s;
            done_r   <= 1'b0;
            reject_r <= host_cmd_wen && busy_r;
            if (state_r == ST_IDLE && seq_start) begin
                poll_cnt_r <= 16'd0;
                last_sr_r  <= 8'd0;
                if (host_cmd_wen) begin
                    // Host wins the tie: the start is refused and reported at once.
                    err_r  <= ERR_REJECT;
                    done_r <= 1'b1;
                end else begin
                    err_r  <= ERR_OK;
                    busy_r <= 1'b1;
                    op_r   <= seq_op;
                    addr_r <= seq_addr;
                    sr_r   <= seq_sr;
                end
            end
            if (fin_s) begin
                err_r  <= fin_err_s;
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
            if (poll_upd_s) begin
                poll_cnt_r <= new_cnt_s;
                last_sr_r  <= iss_result_s;
            end
            if (state_r == ST_GAP) gap_cnt_r <= gap_cnt_r + 32'd1;
            else                   gap_cnt_r <= 32'd0;
        end
    end

    assign seq_busy    = busy_r;
    assign seq_done    = done_r;
    assign host_reject = reject_r;
    assign seq_status  = {poll_cnt_r, last_sr_r, err_r, busy_r, state_r};

endmodule

// File: tb/tb_prom_seq_ctrl.sv
// Directed self-checking bench for prom_seq_ctrl with a simple SPI engine model.
module tb_prom_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] host_cmd = 32'd0;
    logic        host_cmd_wen = 1'b0;
    logic        host_reject;
    logic        seq_start = 1'b0;
    logic [1:0]  seq_op = 2'd0;
    logic [23:0] seq_addr = 24'd0;
    logic [7:0]  seq_sr = 8'd0;
    logic        seq_busy, seq_done;
    logic [31:0] seq_status, eng_cmd;
    logic        eng_cmd_wen;
    logic [2:0]  eng_state = 3'd0;
    logic [31:0] eng_result = 32'd0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prom_seq_ctrl #(.POLL_GAP(3), .POLL_MAX(5), .ENG_LAUNCH_MAX(8)) dut (
        .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_cmd_wen(host_cmd_wen),
        .host_reject(host_reject), .seq_start(seq_start), .seq_op(seq_op),
        .seq_addr(seq_addr), .seq_sr(seq_sr), .seq_busy(seq_busy), .seq_done(seq_done),
        .seq_status(seq_status), .eng_cmd(eng_cmd), .eng_cmd_wen(eng_cmd_wen),
        .eng_state(eng_state), .eng_result(eng_result)
    );

    // Engine model knobs (written by the stimulus only)
    int          eng_lat = 3;
    bit          launch_ok = 1'b1;
    bit          wel_val = 1'b1;
    bit          wip_stuck = 1'b0;
    int          wip_after_op = 0;
    // Engine model state
    int          wip_left = 0;
    int          busy_cnt = 0;
    logic [31:0] res_pend = 32'd0;
    int          viol_cnt = 0;
    logic [31:0] log_q[$];

    // Engine model: busy for eng_lat cycles per command, RDSR reports WEL/WIP
    always @(posedge clk) begin
        if (eng_cmd_wen) begin
            log_q.push_back(eng_cmd);
            if (eng_state != 3'd0) viol_cnt <= viol_cnt + 1;
            if (launch_ok) begin
                eng_state <= 3'd1;
                busy_cnt  <= eng_lat;
                case (eng_cmd[31:24])
                    8'h05: begin
                        res_pend <= {24'h0, 6'h0, wel_val, (wip_stuck || wip_left != 0)};
                        if (wip_left > 0) wip_left <= wip_left - 1;
                    end
                    8'hD8, 8'hC7, 8'h01: begin
                        wip_left <= wip_after_op;
                        res_pend <= 32'd0;
                    end
                    default: res_pend <= 32'd0;
                endcase
            end
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                eng_state  <= 3'd0;
                eng_result <= res_pend;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_seq(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] sr);
        seq_op = op; seq_addr = addr; seq_sr = sr; seq_start = 1'b1;
        tick(1);
        seq_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (seq_done !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_done"}, {31'd0, seq_done}, 32'd1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int k = 0;
        while (seq_status[2:0] !== st && k < budget) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_reach"}, {29'd0, seq_status[2:0]}, {29'd0, st});
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_eng_cmd"}, eng_cmd, 32'd0);
        check_eq({tag, "_wen"}, {31'd0, eng_cmd_wen}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, seq_busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, seq_done}, 32'd0);
        check_eq({tag, "_reject"}, {31'd0, host_reject}, 32'd0);
        check_eq({tag, "_status"}, seq_status, 32'd0);
    endtask

    initial begin
        int base;
        int cnt;

        // Reset values
        tick(2);
        check_reset_vals("rst");
        reset = 1'b0;
        tick(1);

        // Sector erase, 3 busy polls then ready
        wel_val = 1'b1; wip_after_op = 3;
        base = log_q.size();
        start_seq(2'd0, 24'h1F0000, 8'h00);
        check_eq("se_busy_rise", {31'd0, seq_busy}, 32'd1);
        check_eq("se_no_early_wen", {31'd0, eng_cmd_wen}, 32'd0);
        tick(1);
        check_eq("se_no_early_wen2", {31'd0, eng_cmd_wen}, 32'd0);
        tick(1);
        check_eq("se_first_wen", {31'd0, eng_cmd_wen}, 32'd1);
        check_eq("se_first_cmd", eng_cmd, 32'h06000000);
        wait_done("se", 300);
        check_eq("se_busy_clear", {31'd0, seq_busy}, 32'd0);
        tick(1);
        check_eq("se_status", seq_status, 32'h00040200);
        check_eq("se_ncmd", log_q.size() - base, 32'd7);
        check_eq("se_cmd1", log_q[base + 1], 32'h05000000);
        check_eq("se_cmd2", log_q[base + 2], 32'hD81F0000);
        for (int i = 3; i < 7; i++) check_eq("se_poll_cmd", log_q[base + i], 32'h05000000);

        // WEL stuck at 0
        wel_val = 1'b0;
        base = log_q.size();
        start_seq(2'd0, 24'h1F0000, 8'h00);
        wait_done("wel", 200);
        tick(1);
        check_eq("wel_status", seq_status, 32'h00000010);
        check_eq("wel_ncmd", log_q.size() - base, 32'd2);
        check_eq("wel_cmd1", log_q[base + 1], 32'h05000000);
        wel_val = 1'b1;

        // Poll-only with WIP stuck: timeout after POLL_MAX polls
        wip_stuck = 1'b1;
        base = log_q.size();
        start_seq(2'd3, 24'h000000, 8'h00);
        wait_done("tmo", 400);
        tick(1);
        check_eq("tmo_status", seq_status, 32'h00050320);
        check_eq("tmo_ncmd", log_q.size() - base, 32'd5);
        cnt = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i] == 32'h05000000) cnt++;
        check_eq("tmo_all_rdsr", cnt, 32'd5);
        wip_stuck = 1'b0;

        // Host write during a bulk erase is dropped
        wip_after_op = 2;
        start_seq(2'd1, 24'h000000, 8'h00);
        wait_state("rej", 3'd4, 200);
        base = log_q.size();
        host_cmd = 32'h9F000000; host_cmd_wen = 1'b1;
        tick(1);
        host_cmd_wen = 1'b0;
        check_eq("rej_pulse", {31'd0, host_reject}, 32'd1);
        tick(1);
        check_eq("rej_pulse_end", {31'd0, host_reject}, 32'd0);
        wait_done("rej", 300);
        tick(1);
        check_eq("rej_status", seq_status, 32'h00030200);
        cnt = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i] == 32'h9F000000) cnt++;
        check_eq("rej_no_fwd", cnt, 32'd0);

        // Host write in IDLE forwarded with one-cycle latency
        host_cmd = 32'h9F000000; host_cmd_wen = 1'b1;
        tick(1);
        host_cmd_wen = 1'b0;
        check_eq("fwd_wen", {31'd0, eng_cmd_wen}, 32'd1);
        check_eq("fwd_cmd", eng_cmd, 32'h9F000000);
        check_eq("fwd_no_reject", {31'd0, host_reject}, 32'd0);
        tick(6);

        // Simultaneous host write and seq_start: host wins, err=4
        host_cmd = 32'h9F000000; host_cmd_wen = 1'b1; seq_start = 1'b1; seq_op = 2'd0;
        tick(1);
        host_cmd_wen = 1'b0; seq_start = 1'b0;
        check_eq("tie_wen", {31'd0, eng_cmd_wen}, 32'd1);
        check_eq("tie_cmd", eng_cmd, 32'h9F000000);
        check_eq("tie_done", {31'd0, seq_done}, 32'd1);
        check_eq("tie_status", seq_status, 32'h00000040);
        tick(1);
        check_eq("tie_done_end", {31'd0, seq_done}, 32'd0);
        check_eq("tie_not_busy", {31'd0, seq_busy}, 32'd0);
        tick(6);

        // Engine that never leaves IDLE: launch timeout
        launch_ok = 1'b0;
        base = log_q.size();
        start_seq(2'd0, 24'h000000, 8'h00);
        wait_done("hang", 100);
        tick(1);
        check_eq("hang_status", seq_status, 32'h00000030);
        check_eq("hang_ncmd", log_q.size() - base, 32'd1);
        launch_ok = 1'b1;

        // Reset during GAP, then a restart against a busy engine
        wip_after_op = 10;
        start_seq(2'd2, 24'h000000, 8'h5A);
        wait_state("rgap", 3'd4, 200);
        check_eq("rgap_wrsr_cmd", log_q[log_q.size() - 1], 32'h015A0000);
        reset = 1'b1;
        tick(1);
        check_reset_vals("rgap");
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (seq_done === 1'b1) cnt++;
        end
        check_eq("rgap_no_done", cnt, 32'd0);
        eng_lat = 12; wip_after_op = 1;
        base = log_q.size();
        host_cmd = 32'h9F000000; host_cmd_wen = 1'b1;
        tick(1);
        host_cmd_wen = 1'b0;
        start_seq(2'd2, 24'h000000, 8'h5A);
        wait_done("restart", 500);
        tick(1);
        check_eq("restart_status", seq_status, 32'h00020200);
        check_eq("restart_cmd1", log_q[base + 1], 32'h06000000);
        check_eq("no_strobe_while_busy", viol_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prom_seq_ctrl.md
# prom_seq_ctrl

Sequencer and arbiter in front of the M25P16 SPI command engine. It runs multi-step PROM operations (write-enable, WEL check, erase or status write, then WIP polling) autonomously, and shares the engine's single command port with direct host (Firewire) quadlet commands. The block sits between the Firewire register decode and the PROM engine's `prom_cmd`/`prom_reg_wen` inputs, and observes the engine's state and result outputs.

## Interface
Parameters:
- `POLL_GAP`, default 1000: idle cycles between RDSR polls.
- `POLL_MAX`, default 16'hFFFF: maximum RDSR polls before a timeout error.
- `ENG_LAUNCH_MAX`, default 8: cycles allowed for the engine to leave IDLE after a command write.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `host_cmd`  in  32  direct host command quadlet.
- `host_cmd_wen`  in  1  host command write strobe.
- `host_reject`  out  1  one-cycle pulse when a host command is dropped.
- `seq_start`  in  1  start-sequence strobe.
- `seq_op`  in  2  operation: 0 sector erase, 1 bulk erase, 2 write SR, 3 poll only.
- `seq_addr`  in  24  sector address, used by op 0.
- `seq_sr`  in  8  status-register value, used by op 2.
- `seq_busy`  out  1  sequence in progress.
- `seq_done`  out  1  one-cycle pulse when a sequence ends.
- `seq_status`  out  32  {poll_cnt[15:0], last_sr[7:0], err[3:0], busy, state[2:0]}.
- `eng_cmd`  out  32  command quadlet to the engine.
- `eng_cmd_wen`  out  1  engine command strobe.
- `eng_state`  in  3  engine state; 0 means IDLE.
- `eng_result`  in  32  engine result; SR byte in bits [7:0] after RDSR.

## Operation
- The top FSM has these states: IDLE, WREN, WEL_CHK, OPCMD, GAP, POLL, DONE.
- Every engine command goes through the issuer sub-FSM:
  - WAIT_IDLE: wait for `eng_state`==0.
  - ISSUE: drive `eng_cmd`, pulse `eng_cmd_wen` for one cycle.
  - WAIT_BUSY: wait for `eng_state`!=0. Error 3 if it has not left IDLE after `ENG_LAUNCH_MAX` cycles.
  - WAIT_DONE: wait for `eng_state`==0, then report completion to the top FSM.
- Command words (low bits zero):
  - WREN: 0x06000000.
  - RDSR: 0x05000000.
  - Sector erase: {0xD8, seq_addr}.
  - Bulk erase: 0xC7000000.
  - Write SR: {0x01, seq_sr, 16'h0}.
- Ops 0–2 run WREN, then WEL_CHK, then OPCMD, then the GAP/POLL loop.
  - WEL_CHK issues RDSR. If `eng_result[1]`==0, the sequence ends with error 1.
- Op 3 goes straight to the GAP/POLL loop. Host software uses it after a block page program.
- GAP/POLL loop:
  - GAP counts `POLL_GAP` cycles, then POLL issues RDSR.
  - Each poll latches `last_sr` and increments `poll_cnt`, which saturates.
  - If `eng_result[0]` (WIP)==0, go to DONE with error 0. Otherwise return to GAP.
  - When `poll_cnt`==`POLL_MAX` and WIP is still 1, end with error 2.
- DONE: pulse `seq_done`, clear `seq_busy`, return to IDLE. `err` and `last_sr` hold until the next `seq_start`.
- Arbitration:
  - In IDLE, `host_cmd_wen` forwards `host_cmd` to the engine.
  - While `seq_busy`, host writes are dropped and `host_reject` pulses.
  - If `host_cmd_wen` and `seq_start` arrive in the same IDLE cycle, the host wins. The sequence is not started, `seq_done` pulses next cycle, and `err`=4.
- `seq_start` while busy is ignored.

## Timing
- Reset values: `eng_cmd`=0, `eng_cmd_wen`=0, `seq_busy`=0, `seq_done`=0, `host_reject`=0, `seq_status`=0, FSM in IDLE.
- Host pass-through is registered with 1-cycle latency: `eng_cmd_wen` is high the cycle after `host_cmd_wen`.
- `seq_busy` rises the cycle after `seq_start`.
- The first `eng_cmd_wen` of a sequence fires no earlier than 2 cycles after `seq_start`, and only if the engine is idle.
- `eng_cmd_wen` is never asserted while `eng_state`!=0. Consecutive engine strobes are at least 3 cycles apart.
- `eng_result` is sampled in the first cycle that `eng_state` returns to 0 in WAIT_DONE.
- Reset mid-sequence returns the block to IDLE and suppresses `seq_done`.
  - The engine is not reset by this block; an in-flight SPI transfer finishes on its own.
  - A later sequence's WAIT_IDLE absorbs that transfer.
- `poll_cnt` is 16 bits and saturates at 0xFFFF; it does not wrap.

## Structure
- Shared package `prom_seq_pkg` holds:
  - The opcode constants 0x06, 0x05, 0xD8, 0xC7, 0x01.
  - `seq_op` encodings.
  - Error codes: 0 ok, 1 WEL, 2 timeout, 3 engine hang, 4 rejected.
  - Top-FSM state encodings.
- Sub-module `prom_cmd_issuer` implements the handshake: wait idle, strobe, wait busy, wait done, with the launch timeout. It is instantiated once and the top FSM reuses it for every step.

## Test plan
- Sector erase, addr 0x1F0000, engine model with WEL=1 and WIP=1 for 3 polls -> command sequence 0x06000000, 0x05000000, 0xD81F0000, then 4 RDSR; `seq_done`, err=0, poll_cnt=4.
- WEL stuck at 0 after WREN -> sequence ends after the first RDSR with err=1; no 0xD8 command is issued.
- Op 3 with WIP held at 1 and `POLL_MAX`=5 -> exactly 5 RDSR, err=2, poll_cnt=5.
- Host write 0x9F000000 during a sequence -> `host_reject` pulses and the engine sees no strobe. The same write in IDLE -> `eng_cmd_wen` one cycle later with `eng_cmd`=0x9F000000.
- Simultaneous `host_cmd_wen` and `seq_start` in IDLE -> host command forwarded, `seq_done` with err=4. Separately, an engine model that never leaves IDLE -> err=3 after 8 cycles.
- `reset` asserted during GAP -> all outputs return to reset values next cycle, no `seq_done`; a new `seq_start` waits for the engine to be idle before issuing.
